// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the unified-RAM arbiter.
//               - state_e: arbiter states
//               - aim codes: SLB access size encoding
//               - IoRegion: addr[17:16] value of the memory-mapped IO window
//               - beat_count(): number of byte beats for a given aim code
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_READ  = 2'd1,
    LS_READ  = 2'd2,
    LS_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] AimWord = 2'b00;
  localparam logic [1:0] AimByte = 2'b01;
  localparam logic [1:0] AimHalf = 2'b10;

  localparam logic [1:0] IoRegion = 2'b11;

  // Beats per access. The unused aim code 11 falls back to a full word.
  function automatic logic [2:0] beat_count(input logic [1:0] aim);
    case (aim)
      AimByte: beat_count = 3'd1;
      AimHalf: beat_count = 3'd2;
      default: beat_count = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter with a last-grant register.
//               On a tie the requester that did not win last time is chosen.
//               After reset last grant is IF, so the first tie goes to LS.
// Ports       : clk, rst      clock, synchronous active-low reset
//               req_i[1:0]    [0] = IF, [1] = LS
//               accept_i      the current grant is taken on this edge
//               grant_o[1:0]  one-hot grant (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // 0 = IF won last, 1 = LS won last
  logic last_ls_q;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_ls_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_ls_q <= 1'b0;
    end else if (accept_i) begin
      last_ls_q <= grant_o[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Owner of the 8-bit unified RAM port. Arbitrates between the
//               instruction fetcher (word reads) and the store/load buffer
//               (byte/half/word loads and stores), serialises each access into
//               byte beats and reassembles read data little-endian.
// Ports       : clk, rst(active-low sync), rdy(global enable), flush
//               if_req/if_addr -> if_done/if_data        fetch side
//               ls_req/ls_we/ls_aim/ls_addr/ls_wdata
//                 -> ls_done/ls_rdata                    SLB side
//               busy                                     arbiter not idle
//               mem_din, io_buffer_full                  RAM/IO inputs
//               mem_dout, mem_a, mem_wr                  RAM outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         AddrWidth = 32,
  parameter logic [1:0] IoMask    = IoRegion
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic                 if_done,
  output logic [31:0]          if_data,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [1:0]           ls_aim,
  input  logic [AddrWidth-1:0] ls_addr,
  input  logic [31:0]          ls_wdata,
  output logic                 ls_done,
  output logic [31:0]          ls_rdata,
  output logic                 busy,
  input  logic [7:0]           mem_din,
  input  logic                 io_buffer_full,
  output logic [7:0]           mem_dout,
  output logic [AddrWidth-1:0] mem_a,
  output logic                 mem_wr
);

  state_e               state_q;
  logic [2:0]           cnt_q;
  logic [2:0]           n_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rbuf_q;
  logic                 if_done_q;
  logic                 ls_done_q;
  logic [31:0]          if_data_q;
  logic [31:0]          ls_rdata_q;
  logic [AddrWidth-1:0] mem_a_q;
  logic [7:0]           mem_dout_q;
  logic                 mem_wr_q;

  // --------------------------------------------------------------------------
  // Arbitration: only from IDLE, never while flushing, and never in the cycle
  // a done pulse is showing (the requester has not yet dropped its request).
  // --------------------------------------------------------------------------
  logic [1:0] grant;
  logic       grant_ok;
  logic       accept;

  assign grant_ok = (state_q == IDLE) && !flush && !if_done_q && !ls_done_q;
  assign accept   = rdy && grant_ok && (|grant);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({ls_req, if_req}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  // --------------------------------------------------------------------------
  // Write-beat source. The first beat is issued on the accept edge, before
  // the request is latched, so it is taken straight from the SLB inputs.
  // --------------------------------------------------------------------------
  logic [AddrWidth-1:0] beat_base;
  logic [31:0]          beat_data;
  logic [2:0]           beat_idx;
  logic [AddrWidth-1:0] beat_addr_d;
  logic [7:0]           beat_byte_d;
  logic                 io_hold;

  always_comb begin
    beat_base = addr_q;
    beat_data = wdata_q;
    beat_idx  = cnt_q;
    if (state_q == IDLE) begin
      beat_base = ls_addr;
      beat_data = ls_wdata;
      beat_idx  = 3'd0;
    end
  end

  assign beat_addr_d = beat_base + {{(AddrWidth-3){1'b0}}, beat_idx};
  assign io_hold     = io_buffer_full && (beat_base[17:16] == IoMask);

  always_comb begin
    beat_byte_d = beat_data[7:0];
    case (beat_idx[1:0])
      2'd1:    beat_byte_d = beat_data[15:8];
      2'd2:    beat_byte_d = beat_data[23:16];
      2'd3:    beat_byte_d = beat_data[31:24];
      default: beat_byte_d = beat_data[7:0];
    endcase
  end

  // --------------------------------------------------------------------------
  // Read assembly: mem_din carries the byte addressed on the previous edge,
  // i.e. byte cnt_q of the current access.
  // --------------------------------------------------------------------------
  logic [31:0]          rd_word_d;
  logic [2:0]           cnt_inc;
  logic [AddrWidth-1:0] rd_next_a;
  logic                 rd_last;

  assign cnt_inc   = cnt_q + 3'd1;
  assign rd_next_a = addr_q + {{(AddrWidth-3){1'b0}}, cnt_inc};
  assign rd_last   = (cnt_inc == n_q);

  always_comb begin
    rd_word_d = rbuf_q;
    case (cnt_q[1:0])
      2'd0:    rd_word_d[7:0]   = mem_din;
      2'd1:    rd_word_d[15:8]  = mem_din;
      2'd2:    rd_word_d[23:16] = mem_din;
      default: rd_word_d[31:24] = mem_din;
    endcase
  end

  // --------------------------------------------------------------------------
  // Main FSM with registered outputs. rdy=0 freezes every register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_wr_q <= 1'b0;
          if (grant_ok && (|grant)) begin
            cnt_q  <= 3'd0;
            rbuf_q <= 32'd0;
            if (grant[1]) begin
              addr_q  <= ls_addr;
              wdata_q <= ls_wdata;
              n_q     <= beat_count(ls_aim);
              if (ls_we) begin
                // First store beat goes out on the accept edge itself.
                state_q    <= LS_WRITE;
                mem_a_q    <= beat_addr_d;
                mem_dout_q <= beat_byte_d;
                mem_wr_q   <= !io_hold;
                if (!io_hold) begin
                  cnt_q <= 3'd1;
                end
              end else begin
                state_q <= LS_READ;
                mem_a_q <= ls_addr;
              end
            end else begin
              addr_q  <= if_addr;
              n_q     <= 3'd4;
              state_q <= IF_READ;
              mem_a_q <= if_addr;
            end
          end
        end

        IF_READ, LS_READ: begin
          mem_wr_q <= 1'b0;
          if (flush) begin
            // Speculative read abandoned; partial bytes are dropped.
            state_q <= IDLE;
            cnt_q   <= 3'd0;
          end else begin
            rbuf_q <= rd_word_d;
            if (rd_last) begin
              state_q <= IDLE;
              cnt_q   <= 3'd0;
              if (state_q == IF_READ) begin
                if_done_q <= 1'b1;
                if_data_q <= rd_word_d;
              end else begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= rd_word_d;
              end
            end else begin
              cnt_q   <= cnt_inc;
              mem_a_q <= rd_next_a;
            end
          end
        end

        LS_WRITE: begin
          // Stores ignore flush: they are already committed.
          if (cnt_q == n_q) begin
            mem_wr_q  <= 1'b0;
            ls_done_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
          end else begin
            // An IO beat waits while the IO buffer is full; cnt_q holds so
            // the same beat is retried on the next edge.
            mem_a_q    <= beat_addr_d;
            mem_dout_q <= beat_byte_d;
            mem_wr_q   <= !io_hold;
            if (!io_hold) begin
              cnt_q <= cnt_inc;
            end
          end
        end

        default: begin
          state_q  <= IDLE;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy;
  assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. A small RAM
//               model answers reads (data for the address driven on the
//               previous edge) and counts write beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_aim;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        busy;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_aim         (ls_aim),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata),
    .busy           (busy),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  // Read-only RAM image; write beats are only counted.
  logic [7:0] ram [0:65535];
  assign mem_din = ram[mem_a[15:0]];

  int wr_cnt    = 0;
  bit hit_2004  = 1'b0;
  always @(posedge clk) begin
    if (mem_wr) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_a == 32'h0000_2004) hit_2004 <= 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until the selected done pulse is seen; lat = -1 on timeout.
  task automatic wait_done(input bit want_ls, output int lat);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (want_ls ? ls_done : if_done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int lat;
    int n;
    int ord [3];
    int got;

    rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_aim = 2'b00; ls_addr = 32'd0; ls_wdata = 32'd0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'hEE;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0400] = 8'h78; ram[16'h0401] = 8'h56; ram[16'h0402] = 8'h34; ram[16'h0403] = 8'h12;

    // ---------------- reset state ----------------
    tick(); tick();
    check_eq("rst_busy",    busy,     0);
    check_eq("rst_mem_wr",  mem_wr,   0);
    check_eq("rst_mem_a",   mem_a,    0);
    check_eq("rst_dout",    mem_dout, 0);
    check_eq("rst_if_done", if_done,  0);
    check_eq("rst_ls_done", ls_done,  0);
    check_eq("rst_if_data", if_data,  0);
    check_eq("rst_rdata",   ls_rdata, 0);
    rst = 1'b1;
    tick();

    // ---------------- word fetch ----------------
    w0 = wr_cnt;
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("fetch_mem_a", mem_a, 32'h100 + k);
      check_eq("fetch_no_wr", mem_wr, 0);
      check_eq("fetch_early_done", if_done, 0);
    end
    tick();
    check_eq("fetch_done", if_done, 1);
    check_eq("fetch_data", if_data, 32'h0000_0513);
    check_eq("fetch_busy_end", busy, 0);
    if_req = 1'b0;
    tick();
    check_eq("fetch_pulse_1cyc", if_done, 0);
    check_eq("fetch_data_hold", if_data, 32'h0000_0513);
    check_eq("fetch_wr_count", wr_cnt - w0, 0);

    // ---------------- half store ----------------
    w0 = wr_cnt;
    ls_we = 1'b1; ls_aim = 2'b10; ls_addr = 32'h2002; ls_wdata = 32'hAABB_CCDD; ls_req = 1'b1;
    tick();
    check_eq("st_b0_wr",   mem_wr,   1);
    check_eq("st_b0_a",    mem_a,    32'h2002);
    check_eq("st_b0_dout", mem_dout, 32'hDD);
    check_eq("st_b0_busy", busy,     1);
    tick();
    check_eq("st_b1_wr",   mem_wr,   1);
    check_eq("st_b1_a",    mem_a,    32'h2003);
    check_eq("st_b1_dout", mem_dout, 32'hCC);
    tick();
    check_eq("st_end_wr",  mem_wr,   0);
    check_eq("st_done",    ls_done,  1);
    ls_req = 1'b0;
    check_eq("st_wr_count", wr_cnt - w0, 2);
    check_eq("st_no_2004",  hit_2004, 0);
    tick();

    // ---------------- tie after reset ----------------
    rst = 1'b0; tick(); rst = 1'b1; tick();
    if_addr = 32'h100; if_req = 1'b1;
    ls_we = 1'b0; ls_aim = 2'b01; ls_addr = 32'h400; ls_req = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) ord[i] = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      tick();
      if (ls_done) begin
        ord[n] = 2; n++;
        check_eq("tie_ls_data", ls_rdata, 32'h0000_0078);
      end else if (if_done) begin
        ord[n] = 1; n++;
        check_eq("tie_if_data", if_data, 32'h0000_0513);
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    check_eq("tie_count", n, 3);
    check_eq("tie_first_ls",  ord[0], 2);
    check_eq("tie_second_if", ord[1], 1);
    check_eq("tie_third_ls",  ord[2], 2);
    tick();

    // ---------------- flush during fetch ----------------
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    check_eq("flf_busy", busy, 1);
    flush = 1'b1;
    tick();
    check_eq("flf_idle", busy, 0);
    flush = 1'b0; if_req = 1'b0;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (if_done) got = 1;
      tick();
    end
    check_eq("flf_no_done", got, 0);

    // ---------------- flush during word store ----------------
    w0 = wr_cnt;
    ls_we = 1'b1; ls_aim = 2'b00; ls_addr = 32'h3000; ls_wdata = 32'h1122_3344; ls_req = 1'b1;
    tick();
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    wait_done(1'b1, lat);
    ls_req = 1'b0;
    check_eq("fls_latency", lat, 2);
    check_eq("fls_last_a",  mem_a, 32'h3003);
    check_eq("fls_last_d",  mem_dout, 32'h11);
    check_eq("fls_wr_count", wr_cnt - w0, 4);
    tick();

    // ---------------- IO hold ----------------
    w0 = wr_cnt;
    io_buffer_full = 1'b1;
    ls_we = 1'b1; ls_aim = 2'b01; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_005A; ls_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("io_hold_wr", mem_wr, 0);
    end
    io_buffer_full = 1'b0;
    tick();
    check_eq("io_beat_wr",   mem_wr,   1);
    check_eq("io_beat_a",    mem_a,    32'h0003_0000);
    check_eq("io_beat_dout", mem_dout, 32'h5A);
    tick();
    check_eq("io_done",  ls_done, 1);
    check_eq("io_wr_end", mem_wr, 0);
    ls_req = 1'b0;
    check_eq("io_wr_count", wr_cnt - w0, 1);
    tick();

    // ---------------- rdy=0 during a store forces mem_wr low ----------------
    w0 = wr_cnt;
    ls_we = 1'b1; ls_aim = 2'b10; ls_addr = 32'h2010; ls_wdata = 32'h0000_BEEF; ls_req = 1'b1;
    tick();
    rdy = 1'b0;
    #1;
    check_eq("rdy_st_wr_gated", mem_wr, 0);
    tick();
    check_eq("rdy_st_a_frozen", mem_a, 32'h2010);
    check_eq("rdy_st_wr_still", mem_wr, 0);
    rdy = 1'b1;
    #1;
    check_eq("rdy_st_wr_back", mem_wr, 1);
    wait_done(1'b1, lat);
    ls_req = 1'b0;
    check_eq("rdy_st_latency", lat, 2);
    check_eq("rdy_st_wr_count", wr_cnt - w0, 2);
    tick();

    // ---------------- rdy=0 mid word load ----------------
    ls_we = 1'b0; ls_aim = 2'b00; ls_addr = 32'h400; ls_req = 1'b1;
    tick();
    check_eq("rdy_ld_a0", mem_a, 32'h400);
    tick();
    check_eq("rdy_ld_a1", mem_a, 32'h401);
    rdy = 1'b0;
    tick();
    check_eq("rdy_ld_frz_a", mem_a, 32'h401);
    check_eq("rdy_ld_frz_busy", busy, 1);
    tick();
    check_eq("rdy_ld_frz_a2", mem_a, 32'h401);
    check_eq("rdy_ld_frz_done", ls_done, 0);
    rdy = 1'b1;
    wait_done(1'b1, lat);
    ls_req = 1'b0;
    check_eq("rdy_ld_latency", lat, 3);
    check_eq("rdy_ld_data", ls_rdata, 32'h1234_5678);
    tick();

    // ---------------- aim 11 behaves as a word ----------------
    ls_we = 1'b0; ls_aim = 2'b11; ls_addr = 32'h400; ls_req = 1'b1;
    wait_done(1'b1, lat);
    ls_req = 1'b0;
    check_eq("aim11_latency", lat, 5);
    check_eq("aim11_data", ls_rdata, 32'h1234_5678);
    tick();

    // ---------------- half load zero-extends ----------------
    ls_we = 1'b0; ls_aim = 2'b10; ls_addr = 32'h402; ls_req = 1'b1;
    wait_done(1'b1, lat);
    ls_req = 1'b0;
    check_eq("half_latency", lat, 3);
    check_eq("half_data", ls_rdata, 32'h0000_1234);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
